// File: rtl/blvds_frame_transmitter.sv
// BLVDS frame transmitter: drains a show-ahead FIFO into framed packets on the 18-bit bus.
// Optional macro BLVDS_TX_CRC_INJECT_EN adds iCRC_INJECT, which corrupts FE2's FCRC[0] for one frame.
module blvds_frame_transmitter #(
  parameter int FIFO_AW   = 12,
  parameter int GAP_WORDS = 128
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  input  logic [2:0]         iFORMAT,
  input  logic [3:0]         iCHANNELS,
  input  logic [7:0]         iPACK_NUM,
  input  logic [7:0]         iPACK_SIZE,
  input  logic [15:0]        iSAMPLE_NUM,
  input  logic [15:0]        iDATA,
  input  logic [FIFO_AW-1:0] iUSEDW,
`ifdef BLVDS_TX_CRC_INJECT_EN
  input  logic               iCRC_INJECT,
`endif
  output logic               oRD_REQ,
  output logic [17:0]        oDATA_BLVDS,
  output logic               oBUSY,
  output logic               oFRAME_DONE,
  output logic               oCFG_ERR
);

  localparam logic [17:0] IDLE_WORD = 18'h3FE00;

  typedef enum logic [3:0] {
    S_IDLE, S_FH1, S_FH2, S_WAIT, S_PH1, S_PH2, S_DATA,
    S_PE1, S_PE2, S_FE1, S_FE2, S_GAP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  fmt_q;
  logic [3:0]  chan_q;
  logic [7:0]  pnum_q, psize_q, pcnt_q;
  logic [15:0] snum_q, psum_q;
  logic [1:0]  fcnt_q;
  logic [16:0] cnt_q;
  logic [17:0] fsum_q, data_q, word_d;
  logic        done_q, err_q;
  logic        rd_req, fsum_en;

  logic [16:0] n_words;
  logic        accept, pkt_ready, last_word, last_pkt, gap_last;
  logic [15:0] pcrc, fcrc, fcrc_tx;

  // N can reach 65543, so the word count is carried at 17 bits.
  assign n_words   = {1'b0, snum_q} + 17'd8;
  assign accept    = iSTART && (iPACK_NUM != 8'd0);
  assign pkt_ready = 32'(iUSEDW) >= 32'(n_words);
  assign last_word = cnt_q == (n_words - 17'd1);
  assign last_pkt  = (pcnt_q + 8'd1) == pnum_q;
  assign gap_last  = cnt_q == 17'(GAP_WORDS - 1);
  assign pcrc      = ~psum_q;
  assign fcrc      = ~fsum_q[15:0];

`ifdef BLVDS_TX_CRC_INJECT_EN
  logic inj_q;
  assign fcrc_tx = fcrc ^ {15'd0, inj_q};
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)                          inj_q <= 1'b0;
    else if (state_q == S_IDLE && accept) inj_q <= iCRC_INJECT;
  end
`else
  assign fcrc_tx = fcrc;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_FH1;
      S_FH1:  state_d = S_FH2;
      S_FH2:  state_d = S_WAIT;
      S_WAIT: if (pkt_ready) state_d = S_PH1;
      S_PH1:  state_d = S_PH2;
      S_PH2:  state_d = S_DATA;
      S_DATA: if (last_word) state_d = S_PE1;
      S_PE1:  state_d = S_PE2;
      S_PE2:  state_d = last_pkt ? S_FE1 : S_WAIT;
      S_FE1:  state_d = S_FE2;
      S_FE2:  state_d = S_GAP;
      S_GAP:  if (gap_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // fsum_en marks the words covered by FCRC; idle fill in WAIT is not part of the frame.
  always_comb begin
    word_d  = IDLE_WORD;
    rd_req  = 1'b0;
    fsum_en = 1'b0;
    case (state_q)
      S_FH1:  begin word_d = {2'b11, 3'b000, fmt_q, fcnt_q, pnum_q};        fsum_en = 1'b1; end
      S_FH2:  begin word_d = {2'b11, 3'b001, 1'b0, chan_q, psize_q};        fsum_en = 1'b1; end
      S_PH1:  begin word_d = {2'b11, 3'b010, pcnt_q[4:0], snum_q[15:8]};   fsum_en = 1'b1; end
      S_PH2:  begin word_d = {2'b11, 3'b011, 5'd0, snum_q[7:0]};           fsum_en = 1'b1; end
      S_DATA: begin word_d = {2'b00, iDATA}; rd_req = 1'b1;                fsum_en = 1'b1; end
      S_PE1:  begin word_d = {2'b11, 3'b110, 5'd0, pcrc[15:8]};            fsum_en = 1'b1; end
      S_PE2:  begin word_d = {2'b11, 8'hE0, pcrc[7:0]};                    fsum_en = 1'b1; end
      S_FE1:  word_d = {2'b11, 8'h80, fcrc_tx[15:8]};
      S_FE2:  word_d = {2'b11, 3'b101, 5'd0, fcrc_tx[7:0]};
      default: word_d = IDLE_WORD;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      data_q  <= IDLE_WORD;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fmt_q   <= '0;
      chan_q  <= '0;
      pnum_q  <= '0;
      psize_q <= '0;
      snum_q  <= '0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
      cnt_q   <= '0;
      psum_q  <= '0;
      fsum_q  <= '0;
    end else begin
      data_q <= word_d;
      done_q <= (state_q == S_GAP) && gap_last;
      err_q  <= (state_q == S_IDLE) && iSTART && (iPACK_NUM == 8'd0);
      if (state_q == S_IDLE && accept) begin
        fmt_q   <= iFORMAT;
        chan_q  <= iCHANNELS;
        pnum_q  <= iPACK_NUM;
        psize_q <= iPACK_SIZE;
        snum_q  <= iSAMPLE_NUM;
        pcnt_q  <= '0;
        fsum_q  <= '0;
      end else if (fsum_en) begin
        fsum_q <= fsum_q + word_d;
      end
      // One counter serves the data run and the inter-frame gap.
      if (state_q == S_PH2 || state_q == S_FE2)        cnt_q <= '0;
      else if (state_q == S_DATA || state_q == S_GAP)  cnt_q <= cnt_q + 17'd1;
      if (state_q == S_PH1)       psum_q <= '0;
      else if (state_q == S_DATA) psum_q <= psum_q + iDATA;
      if (state_q == S_PE2) pcnt_q <= pcnt_q + 8'd1;
      if (state_q == S_FE2) fcnt_q <= fcnt_q + 2'd1;
    end
  end

  assign oRD_REQ     = rd_req;
  assign oDATA_BLVDS = data_q;
  assign oBUSY       = state_q != S_IDLE;
  assign oFRAME_DONE = done_q;
  assign oCFG_ERR    = err_q;

endmodule

// File: tb/tb_blvds_frame_transmitter.sv
// Directed bench for blvds_frame_transmitter: vector table of frame configs plus corner-case sequences.
module tb_blvds_frame_transmitter;
  localparam int FIFO_AW = 12;
  localparam logic [17:0] IDLE_W = 18'h3FE00;

  logic               iCLK = 1'b0;
  logic               iRST = 1'b1;
  logic               iSTART = 1'b0;
  logic [2:0]         iFORMAT = '0;
  logic [3:0]         iCHANNELS = '0;
  logic [7:0]         iPACK_NUM = '0;
  logic [7:0]         iPACK_SIZE = '0;
  logic [15:0]        iSAMPLE_NUM = '0;
  logic [15:0]        iDATA;
  logic [FIFO_AW-1:0] iUSEDW;
`ifdef BLVDS_TX_CRC_INJECT_EN
  logic               iCRC_INJECT = 1'b0;
`endif
  logic               oRD_REQ, oBUSY, oFRAME_DONE, oCFG_ERR;
  logic [17:0]        oDATA_BLVDS;

  blvds_frame_transmitter #(.FIFO_AW(FIFO_AW), .GAP_WORDS(128)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iFORMAT(iFORMAT),
    .iCHANNELS(iCHANNELS), .iPACK_NUM(iPACK_NUM), .iPACK_SIZE(iPACK_SIZE),
    .iSAMPLE_NUM(iSAMPLE_NUM), .iDATA(iDATA), .iUSEDW(iUSEDW),
`ifdef BLVDS_TX_CRC_INJECT_EN
    .iCRC_INJECT(iCRC_INJECT),
`endif
    .oRD_REQ(oRD_REQ), .oDATA_BLVDS(oDATA_BLVDS), .oBUSY(oBUSY),
    .oFRAME_DONE(oFRAME_DONE), .oCFG_ERR(oCFG_ERR));

  always #5 iCLK = ~iCLK;

  // Show-ahead FIFO model
  logic [15:0] fifo_mem [0:65535];
  int wr_ptr = 0, rd_ptr = 0, usedw_ovr = -1;
  assign iDATA  = fifo_mem[rd_ptr[15:0]];
  assign iUSEDW = (usedw_ovr >= 0) ? FIFO_AW'(usedw_ovr) : FIFO_AW'(wr_ptr - rd_ptr);
  always @(posedge iCLK) if (oRD_REQ) rd_ptr <= rd_ptr + 1;

  // Output monitor
  logic [17:0] cap[$];
  int done_cnt = 0, err_cnt = 0, rd_cnt = 0;
  int gap_run = 0, min_gap = 1 << 30, n_gaps = 0;
  bit seen_fe2 = 1'b0;
  always @(negedge iCLK) begin
    if (oDATA_BLVDS != IDLE_W) cap.push_back(oDATA_BLVDS);
    if (oFRAME_DONE) done_cnt <= done_cnt + 1;
    if (oCFG_ERR)    err_cnt  <= err_cnt + 1;
    if (oRD_REQ)     rd_cnt   <= rd_cnt + 1;
    if (oDATA_BLVDS[17:13] == 5'b11101) begin
      seen_fe2 <= 1'b1; gap_run <= 0;
    end else if (oDATA_BLVDS == IDLE_W) begin
      gap_run <= gap_run + 1;
    end else if (oDATA_BLVDS[17:13] == 5'b11000 && seen_fe2) begin
      if (gap_run < min_gap) min_gap <= gap_run;
      n_gaps <= n_gaps + 1; seen_fe2 <= 1'b0;
    end
  end

  int checks = 0, fails = 0;
  logic [17:0] exp_q[$];
  logic [17:0] fe2_ok;
  logic [1:0]  exp_fcnt = 2'd0;
  int cap_base = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic start_frame(input logic [2:0] fmt, input logic [3:0] chan, input logic [7:0] pnum,
                             input logic [7:0] psize, input logic [15:0] snum, input bit seq, input bit inj);
    logic [17:0] w, fs;
    logic [15:0] ps, d, pc, fc;
    logic [7:0]  pb;
    int n;
    n = int'(snum) + 8;
    exp_q.delete();
    fs = '0;
    w = {2'b11, 3'b000, fmt, exp_fcnt, pnum}; exp_q.push_back(w); fs += w;
    w = {2'b11, 3'b001, 1'b0, chan, psize};   exp_q.push_back(w); fs += w;
    for (int p = 0; p < int'(pnum); p++) begin
      pb = 8'(p);
      w = {2'b11, 3'b010, pb[4:0], snum[15:8]}; exp_q.push_back(w); fs += w;
      w = {2'b11, 3'b011, 5'd0, snum[7:0]};     exp_q.push_back(w); fs += w;
      ps = '0;
      for (int i = 0; i < n; i++) begin
        d = seq ? 16'(i + 1) : 16'($urandom);
        fifo_mem[wr_ptr[15:0]] = d; wr_ptr++;
        ps += d;
        w = {2'b00, d}; exp_q.push_back(w); fs += w;
      end
      pc = ~ps;
      w = {2'b11, 3'b110, 5'd0, pc[15:8]}; exp_q.push_back(w); fs += w;
      w = {2'b11, 8'hE0, pc[7:0]};         exp_q.push_back(w); fs += w;
    end
    fc = ~fs[15:0];
    fe2_ok = {2'b11, 3'b101, 5'd0, fc[7:0]};
    if (inj) fc[0] = ~fc[0];
    exp_q.push_back({2'b11, 8'h80, fc[15:8]});
    exp_q.push_back({2'b11, 3'b101, 5'd0, fc[7:0]});
    iFORMAT = fmt; iCHANNELS = chan; iPACK_NUM = pnum; iPACK_SIZE = psize; iSAMPLE_NUM = snum;
`ifdef BLVDS_TX_CRC_INJECT_EN
    iCRC_INJECT = inj;
`endif
    cap_base = cap.size();
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  task automatic finish_frame(input string nm);
    int k, got;
    k = 0;
    while (!oFRAME_DONE && k < 5000) begin @(negedge iCLK); k++; end
    chk({nm, "_done"}, {31'd0, oFRAME_DONE}, 32'd1);
    chk({nm, "_busy_clr"}, {31'd0, oBUSY}, 32'd0);
    got = cap.size() - cap_base;
    chk({nm, "_len"}, got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got; i++)
      chk($sformatf("%s_w%0d", nm, i), {14'd0, cap[cap_base + i]}, {14'd0, exp_q[i]});
    exp_fcnt = exp_fcnt + 2'd1;
  endtask

  typedef struct {
    logic [2:0]  fmt;
    logic [3:0]  chan;
    logic [7:0]  pnum, psize;
    logic [15:0] snum;
    bit          seq;
    logic [17:0] e_fh1, e_fh2, e_ph2, e_pe1, e_pe2, e_fe1, e_fe2;
  } vec_t;
  vec_t vt[3];

  initial begin
    int d0, e0, r0, got;
    // hand-computed words; zero marks "checked by the model only"
    vt[0] = '{3'd0, 4'h0, 8'd1, 8'h00, 16'h0000, 1'b1,
              18'h30001, 18'h32000, 18'h36000, 18'h3C0FF, 18'h3E0DB, 18'h3809E, 18'h3A000};
    vt[1] = '{3'd5, 4'hA, 8'd3, 8'h42, 16'h0002, 1'b0,
              18'h31503, 18'h32A42, 18'h36002, 18'h0, 18'h0, 18'h0, 18'h0};
    vt[2] = '{3'd7, 4'hF, 8'd2, 8'hFF, 16'h0105, 1'b0,
              18'h31E02, 18'h32FFF, 18'h36005, 18'h0, 18'h0, 18'h0, 18'h0};

    repeat (3) @(negedge iCLK);
    chk("rst_data", {14'd0, oDATA_BLVDS}, {14'd0, IDLE_W});
    chk("rst_rdreq", {31'd0, oRD_REQ}, 32'd0);
    chk("rst_busy", {31'd0, oBUSY}, 32'd0);
    chk("rst_done", {31'd0, oFRAME_DONE}, 32'd0);
    chk("rst_cfgerr", {31'd0, oCFG_ERR}, 32'd0);
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);

    // Table frames, plus two more back-to-back to complete FCNT 0,1,2,3,0
    d0 = done_cnt;
    for (int v = 0; v < 3; v++) begin
      start_frame(vt[v].fmt, vt[v].chan, vt[v].pnum, vt[v].psize, vt[v].snum, vt[v].seq, 1'b0);
      finish_frame($sformatf("vec%0d", v));
      got = cap.size() - cap_base;
      if (got >= 6) begin
        chk($sformatf("vec%0d_fh1", v), {14'd0, cap[cap_base]},     {14'd0, vt[v].e_fh1});
        chk($sformatf("vec%0d_fh2", v), {14'd0, cap[cap_base + 1]}, {14'd0, vt[v].e_fh2});
        chk($sformatf("vec%0d_ph2", v), {14'd0, cap[cap_base + 3]}, {14'd0, vt[v].e_ph2});
        if (vt[v].e_fe1 != 18'h0) begin
          chk($sformatf("vec%0d_pe1", v), {14'd0, cap[cap.size() - 4]}, {14'd0, vt[v].e_pe1});
          chk($sformatf("vec%0d_pe2", v), {14'd0, cap[cap.size() - 3]}, {14'd0, vt[v].e_pe2});
          chk($sformatf("vec%0d_fe1", v), {14'd0, cap[cap.size() - 2]}, {14'd0, vt[v].e_fe1});
          chk($sformatf("vec%0d_fe2", v), {14'd0, cap[cap.size() - 1]}, {14'd0, vt[v].e_fe2});
        end
      end
    end
    for (int f = 0; f < 2; f++) begin
      start_frame(3'd2, 4'h3, 8'd2, 8'h10, 16'h0001, 1'b0, 1'b0);
      finish_frame($sformatf("b2b%0d", f));
      chk($sformatf("b2b%0d_fcnt", f), {30'd0, cap[cap_base][9:8]}, (f == 0) ? 32'd3 : 32'd0);
    end
    @(negedge iCLK);
    chk("b2b_done_pulses", done_cnt - d0, 5);
    chk("b2b_gaps_seen", n_gaps >= 4, 1);
    chk("b2b_gap_min128", min_gap >= 128, 1);

    // FIFO starved at N-1 for 50 cycles
    usedw_ovr = 7;
    r0 = rd_cnt;
    start_frame(3'd1, 4'h1, 8'd1, 8'h01, 16'h0000, 1'b0, 1'b0);
    repeat (50) @(negedge iCLK);
    chk("starve_hdr_only", cap.size() - cap_base, 2);
    chk("starve_no_rdreq", rd_cnt - r0, 0);
    chk("starve_busy", {31'd0, oBUSY}, 32'd1);
    usedw_ovr = -1;
    finish_frame("starve");

    // Zero packet count is rejected
    e0 = err_cnt;
    iPACK_NUM = 8'd0; iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    chk("cfgerr_pulse", {31'd0, oCFG_ERR}, 32'd1);
    repeat (3) @(negedge iCLK);
    chk("cfgerr_count", err_cnt - e0, 1);
    chk("cfgerr_busy", {31'd0, oBUSY}, 32'd0);

`ifdef BLVDS_TX_CRC_INJECT_EN
    start_frame(3'd3, 4'h5, 8'd1, 8'h07, 16'h0003, 1'b0, 1'b1);
    finish_frame("inject");
    chk("inject_fe2_bit0", {14'd0, cap[cap.size() - 1] ^ fe2_ok}, 32'd1);
`endif

    // Reset while streaming data
    start_frame(3'd0, 4'h2, 8'd1, 8'h00, 16'd20, 1'b0, 1'b0);
    begin
      int k = 0;
      while (!oRD_REQ && k < 200) begin @(negedge iCLK); k++; end
    end
    chk("rstmid_in_data", {31'd0, oRD_REQ}, 32'd1);
    #2 iRST = 1'b1;
    #1;
    chk("rstmid_idle_word", {14'd0, oDATA_BLVDS}, {14'd0, IDLE_W});
    chk("rstmid_rdreq", {31'd0, oRD_REQ}, 32'd0);
    chk("rstmid_busy", {31'd0, oBUSY}, 32'd0);
    @(negedge iCLK);
    iRST = 1'b0;
    wr_ptr = rd_ptr;
    exp_fcnt = 2'd0;
    @(negedge iCLK);
    start_frame(3'd6, 4'h9, 8'd1, 8'h22, 16'h0000, 1'b1, 1'b0);
    finish_frame("post_rst");
    chk("post_rst_fcnt", {30'd0, cap[cap_base][9:8]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/blvds_frame_transmitter.md
Name: blvds_frame_transmitter

Overview:
- Upstream stage of the BLVDS link. It drains samples from a show-ahead FIFO and serialises them onto the 18-bit BLVDS bus as framed packets.
- Each frame is: frame header, packets (each with header, data and epilog), then frame epilog, with idle words between frames.
- Produces exactly the word format, CRC rule and inter-frame gap that the downstream BLVDS receiver checks.

Parameters:
- FIFO_AW, 12, width of source FIFO used-words count.
- GAP_WORDS, 128, minimum idle words sent after each frame epilog (must be ≥ 101).

Ports:
- iCLK  in  1  clock
- iRST  in  1  async active-high reset
- iSTART  in  1  one-cycle request to send a frame; ignored while oBUSY
- iFORMAT  in  3  frame format field
- iCHANNELS  in  4  channel mask field
- iPACK_NUM  in  8  packets per frame (1..255)
- iPACK_SIZE  in  8  mode/scale field
- iSAMPLE_NUM  in  16  sample field; data words per packet N = iSAMPLE_NUM+8
- iDATA  in  16  FIFO show-ahead data
- iUSEDW  in  FIFO_AW  FIFO used words
- oRD_REQ  out  1  FIFO read acknowledge
- oDATA_BLVDS  out  18  BLVDS word, registered
- oBUSY  out  1  frame in progress (including gap)
- oFRAME_DONE  out  1  one-cycle pulse after last gap word
- oCFG_ERR  out  1  one-cycle pulse when iSTART is rejected

Behaviour:
- Reset (async): state IDLE; oDATA_BLVDS=18'h3FE00; oRD_REQ=0; oBUSY=0; oFRAME_DONE=0; oCFG_ERR=0; frame counter=0; CRC accumulators=0.
- IDLE: drives 18'h3FE00 continuously.
  - iSTART with iPACK_NUM=0: oCFG_ERR pulses and state stays IDLE.
  - Otherwise all config inputs are latched, oBUSY=1, frame CRC accumulator cleared, next state FH.
- Word formats (bits 17:16=2'b11 for all service words):
  - FH1: 3'b000,FORMAT,FCNT[1:0],PACK_NUM
  - FH2: 3'b001,1'b0,CHANNELS,PACK_SIZE
  - PH1: 3'b010,PCNT[4:0],SAMPLE_NUM[15:8]
  - PH2: 3'b011,5'b0,SAMPLE_NUM[7:0]
  - PE1: 3'b110,5'b0,PCRC[15:8]
  - PE2: 8'hE0,PCRC[7:0]
  - FE1: 8'h80,FCRC[15:8]
  - FE2: 3'b101,5'b0,FCRC[7:0]
- Data words: {2'b00,iDATA}.
- Sequence:
  - FH1,FH2 → WAIT.
  - WAIT drives idle words until iUSEDW ≥ N, then PH1,PH2.
  - DATA sends N consecutive data words with no gaps.
  - PE1,PE2.
  - If packets sent == PACK_NUM → FE1,FE2, else back to WAIT.
  - FE2 is followed by the GAP state.
- WAIT is entered only between FH2 and PH1, or between PE2 and the next PH1. The packet header is never emitted until the whole packet is buffered. If iUSEDW never reaches N, the block waits indefinitely; only reset recovers it.
- DATA timing: oRD_REQ=1 combinationally in each DATA cycle. iDATA sampled that cycle appears on oDATA_BLVDS the next cycle. Exactly N reads per packet.
- PCNT: 0 for first packet of a frame, +1 per packet, wraps mod 32.
- FCNT: +1 per completed frame, wraps mod 4.
- PCRC = ~(16-bit sum of the packet's data payloads).
- FCRC = ~(sum[15:0] of the 18-bit accumulated sum of every word from FH1 through the last PE2 inclusive). Accumulator is 18 bits, wraps; FE words are excluded.
- GAP: GAP_WORDS idle words, then oFRAME_DONE pulse, oBUSY=0, IDLE.
- N width: 17 bits internally; iSAMPLE_NUM=16'hFFFF gives N=65543, so the count must not overflow.
- Reset mid-frame: output immediately returns to idle word; partial frame abandoned; FCNT cleared.
- iSTART during oBUSY: ignored, no oCFG_ERR.

Optional Feature:
- Macro BLVDS_TX_CRC_INJECT_EN.
- Defined: extra input iCRC_INJECT (1 bit), latched at iSTART. When set, FCRC[0] is inverted in FE2 for that frame, to exercise the receiver's CRC-fail path (expected marker 16'h00F0).
- Undefined: no port; FCRC always correct.

Test Plan:
- Single frame, PACK_NUM=1, SAMPLE_NUM=0, FIFO preloaded with 8 words 0x0001..0x0008. Required sequence: FH1=18'h30001, FH2, PH1=18'h34000, PH2=18'h36000, 8 data words, PE1/PE2 with PCRC=~0x0024=0xFFDB, correct FE1/FE2. Total FH1..PE2 sum matches the FCRC complement.
- PACK_NUM=3 → PCNT fields 0,1,2. Exactly one frame epilog pair, after third PE2.
- FIFO starved (iUSEDW=N-1 for 50 cycles, then N) → idle words for those cycles, PH1 only after iUSEDW=N, no oRD_REQ while waiting.
- Five back-to-back frames → FCNT 0,1,2,3,0. At least 128 idle words between FE2 and next FH1. oFRAME_DONE once per frame.
- iSTART with iPACK_NUM=0 → oCFG_ERR one pulse, oBUSY stays 0. iRST asserted during DATA → next word 18'h3FE00 and oRD_REQ=0.
- BLVDS_TX_CRC_INJECT_EN defined, iCRC_INJECT=1 → FE2 low byte differs from the correct value only in bit 0.
